uart_rx_param: RTL

Parametrised, fully synchronous UART receiver replacing the fixed 9600-baud behavioural receiver. It samples the serial line `dcom` with the system clock, deframes start/data/(parity)/stop bits, detects false starts and framing errors, and buffers received words in a small FIFO drained through a valid/ready handshake. It sits between the board serial pin and any byte-consuming logic on the system bus.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx_param.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Counts data bits (max 9) and stop bits (max 2) within a frame.
    localparam int unsigned BIT_CNT_W = 4;

    // Width of the bit-clock counter, which runs 0..clks_per_bit-1.
    function automatic int unsigned bit_clk_w(input int unsigned clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bus: serial line in, buffered words out through valid/ready.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 dcom;
    logic [DATA_BITS-1:0] bus;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  dcom, rx_ready,
        output bus, rx_valid, frame_err, parity_err, overrun, busy
    );

    modport slave (
        output dcom, rx_ready,
        input  bus, rx_valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; a pop frees room for a push in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overrun
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             pop_c;
    logic             push_ok_c;

    always_comb begin
        pop_c     = pop && (count != '0);
        push_ok_c = push && ((count < CW'(DEPTH)) || pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(push_ok_c) - CW'(pop_c);
            overrun <= push && !push_ok_c;
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, deframer FSM and receive FIFO.
// Optional parity bit checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_ODD   = 0
) (
    input logic              clk,
    input logic              rst,
    uart_rx_param_if.master  bif
);
    localparam int unsigned CNT_W = bit_clk_w(CLKS_PER_BIT);
    localparam int unsigned ENT_W = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4)                   begin : g_bad_cpb    $error("CLKS_PER_BIT must be >= 4");       end
    if (DATA_BITS < 5 || DATA_BITS > 9)     begin : g_bad_db     $error("DATA_BITS must be 5..9");          end
    if (STOP_BITS < 1 || STOP_BITS > 2)     begin : g_bad_sb     $error("STOP_BITS must be 1 or 2");        end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
                                            begin : g_bad_depth  $error("FIFO_DEPTH must be a power of 2"); end
    if (PARITY_ODD > 1)                     begin : g_bad_par    $error("PARITY_ODD must be 0 or 1");       end

    uart_rx_state_t       state;
    logic                 sync1;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
    logic                 perr;
    logic                 push;
    logic [ENT_W-1:0]     push_data;
    logic [ENT_W-1:0]     head;
    logic                 valid;

    // Deframer; every sample point is where cnt reaches HALF_M1 (start) or FULL_M1 (others).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
            bif.busy  <= 1'b0;
        end else begin
            sync1 <= bif.dcom;
            rxs   <= sync1;
            push  <= 1'b0;
            cnt   <= cnt + CNT_W'(1);
            case (state)
                WAIT_IDLE: if (rxs) state <= IDLE;
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state    <= START;
                        bif.busy <= 1'b1;
                    end
                end
                START: if (cnt == HALF_M1) begin
                    cnt <= '0;
                    if (rxs) begin
                        state    <= IDLE;
                        bif.busy <= 1'b0;
                    end else begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        ferr    <= 1'b0;
                        perr    <= 1'b0;
                    end
                end
                DATA: if (cnt == FULL_M1) begin
                    cnt     <= '0;
                    shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == FULL_M1) begin
                    cnt   <= '0;
                    perr  <= rxs ^ (^shreg) ^ 1'(PARITY_ODD);
                    state <= STOP;
                end
`endif
                STOP: if (cnt == FULL_M1) begin
                    cnt     <= '0;
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (!rxs) ferr <= 1'b1;
                    if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
                        push      <= 1'b1;
                        push_data <= {perr, ferr | ~rxs, shreg};
                        state     <= rxs ? IDLE : WAIT_IDLE;
                        bif.busy  <= 1'b0;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (bif.rx_ready),
        .head      (head),
        .valid     (valid),
        .overrun   (bif.overrun)
    );

    assign bif.bus       = head[DATA_BITS-1:0];
    assign bif.frame_err = head[DATA_BITS];
    assign bif.rx_valid  = valid;
`ifdef UART_RX_PARITY_EN
    assign bif.parity_err = head[DATA_BITS+1];
`else
    assign bif.parity_err = 1'b0;
`endif

endmodule
